// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for the 14-instruction MIPS subset: IF/ID/EXE/MEM/WB FSM
// with fixed-latency memory waits and a retired-instruction counter.
module multicycle_controller #(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 4,
   parameter int ALUOP_W = 3,
   parameter int RET_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OpCode,
   input  logic [5:0]         func,
   input  logic               Zero,
   input  logic               Gtz,
   output logic               PCWrite,
   output logic [1:0]         PCSrc,
   output logic               IRWrite,
   output logic [1:0]         RegDst,
   output logic               ALUSrc,
   output logic [1:0]         Extop,
   output logic [ALUOP_W-1:0] ALUop,
   output logic [1:0]         Mem_to_Reg,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic [2:0]         state,
   output logic               illegal,
   output logic [RET_W-1:0]   retired
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EXE = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   logic [2:0]       nextState;
   logic [CNT_W-1:0] waitCnt;
   logic             memDone;
   logic             retire;

   logic isRtype, isAddu, isSubu, isSlt, isJr, isOri, isLw, isSw, isBeq;
   logic isLui, isJ, isAddi, isAddiu, isJal, isBgtz, isValid;

   logic       pcWriteC, irWriteC, regWriteC, memWriteC, illegalC;
   logic [1:0] pcSrcC;

   always_comb begin
      isRtype = (OpCode == 6'b000000);
      isAddu  = isRtype && (func == 6'b100001);
      isSubu  = isRtype && (func == 6'b100011);
      isSlt   = isRtype && (func == 6'b101010);
      isJr    = isRtype && (func == 6'b001000);
      isOri   = (OpCode == 6'b001101);
      isLw    = (OpCode == 6'b100011);
      isSw    = (OpCode == 6'b101011);
      isBeq   = (OpCode == 6'b000100);
      isLui   = (OpCode == 6'b001111);
      isJ     = (OpCode == 6'b000010);
      isAddi  = (OpCode == 6'b001000);
      isAddiu = (OpCode == 6'b001001);
      isJal   = (OpCode == 6'b000011);
      isBgtz  = (OpCode == 6'b000111);
      isValid = isAddu | isSubu | isSlt | isJr | isOri | isLw | isSw | isBeq |
                isLui | isJ | isAddi | isAddiu | isJal | isBgtz;
   end

   // Selects follow the held IR from ID onward; forced to 0 while fetching.
   always_comb begin
      RegDst     = 2'b00;
      ALUSrc     = 1'b0;
      Extop      = 2'b00;
      ALUop      = '0;
      Mem_to_Reg = 2'b00;
      if (state != S_IF) begin
         if (isAddu || isSubu || isSlt || isJr) RegDst = 2'b01;
         if (isSubu || isBeq || isBgtz)         ALUop = ALUOP_W'(1);
         if (isOri)                             ALUop = ALUOP_W'(2);
         if (isSlt)                             ALUop = ALUOP_W'(3);
         if (isLw || isSw || isAddi || isAddiu) begin
            Extop  = 2'b01;
            ALUSrc = 1'b1;
         end
         if (isOri || isLui) ALUSrc = 1'b1;
         if (isLui)          Extop  = 2'b10;
         if (isJal) begin
            RegDst     = 2'b10;
            Mem_to_Reg = 2'b10;
         end
         if (isLw) Mem_to_Reg = 2'b01;
      end
   end

   assign memDone = (waitCnt == CNT_W'(MEM_LAT - 1));

   always_comb begin
      nextState = state;
      pcWriteC  = 1'b0;
      pcSrcC    = 2'b00;
      irWriteC  = 1'b0;
      regWriteC = 1'b0;
      memWriteC = 1'b0;
      illegalC  = 1'b0;
      retire    = 1'b0;
      case (state)
         S_IF: begin
            if (memDone) begin
               irWriteC  = 1'b1;
               pcWriteC  = 1'b1;
               nextState = S_ID;
            end
         end
         S_ID: begin
            if (!isValid) begin
               illegalC  = 1'b1;
               nextState = S_IF;
            end else if (isJ || isJal) begin
               pcWriteC  = 1'b1;
               pcSrcC    = 2'b10;
               regWriteC = isJal;
               nextState = S_IF;
               retire    = 1'b1;
            end else if (isJr) begin
               pcWriteC  = 1'b1;
               pcSrcC    = 2'b11;
               nextState = S_IF;
               retire    = 1'b1;
            end else begin
               nextState = S_EXE;
            end
         end
         S_EXE: begin
            if (isBeq || isBgtz) begin
               pcWriteC  = isBeq ? Zero : Gtz;
               pcSrcC    = 2'b01;
               nextState = S_IF;
               retire    = 1'b1;
            end else if (isLw || isSw) begin
               nextState = S_MEM;
            end else begin
               nextState = S_WB;
            end
         end
         S_MEM: begin
            if (memDone) begin
               memWriteC = isSw;
               nextState = isSw ? S_IF : S_WB;
               retire    = isSw;
            end
         end
         S_WB: begin
            regWriteC = 1'b1;
            nextState = S_IF;
            retire    = 1'b1;
         end
         default: nextState = S_IF;
      endcase
   end

   // Enables are masked by reset directly so an async reset cannot leave a partial write.
   assign PCWrite  = pcWriteC  & ~reset;
   assign PCSrc    = pcSrcC & {2{~reset}};
   assign IRWrite  = irWriteC  & ~reset;
   assign RegWrite = regWriteC & ~reset;
   assign MemWrite = memWriteC & ~reset;
   assign illegal  = illegalC  & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IF;
         waitCnt <= '0;
         retired <= '0;
      end else begin
         state <= nextState;
         if ((nextState != state) && (nextState == S_IF || nextState == S_MEM))
            waitCnt <= '0;
         else if (state == S_IF || state == S_MEM)
            waitCnt <= waitCnt + CNT_W'(1);
         else
            waitCnt <= '0;
         if (retire)
            retired <= retired + RET_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: three instances at MEM_LAT 1, 2 and 3
// share inputs and reset; each scenario exercises one instance cycle by cycle.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] OpCode = 6'b0;
   logic [5:0] func = 6'b0;
   logic       Zero = 1'b0;
   logic       Gtz = 1'b0;

   logic        pcWrite[3];
   logic [1:0]  pcSrc[3];
   logic        irWrite[3];
   logic [1:0]  regDst[3];
   logic        aluSrc[3];
   logic [1:0]  extop[3];
   logic [2:0]  aluOp[3];
   logic [1:0]  memToReg[3];
   logic        regWrite[3];
   logic        memWrite[3];
   logic [2:0]  state[3];
   logic        illegal[3];
   logic [31:0] retired[3];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .OpCode(OpCode), .func(func), .Zero(Zero), .Gtz(Gtz),
      .PCWrite(pcWrite[0]), .PCSrc(pcSrc[0]), .IRWrite(irWrite[0]), .RegDst(regDst[0]),
      .ALUSrc(aluSrc[0]), .Extop(extop[0]), .ALUop(aluOp[0]), .Mem_to_Reg(memToReg[0]),
      .RegWrite(regWrite[0]), .MemWrite(memWrite[0]), .state(state[0]),
      .illegal(illegal[0]), .retired(retired[0]));

   multicycle_controller #(.MEM_LAT(2)) dut2 (
      .clk(clk), .reset(reset), .OpCode(OpCode), .func(func), .Zero(Zero), .Gtz(Gtz),
      .PCWrite(pcWrite[1]), .PCSrc(pcSrc[1]), .IRWrite(irWrite[1]), .RegDst(regDst[1]),
      .ALUSrc(aluSrc[1]), .Extop(extop[1]), .ALUop(aluOp[1]), .Mem_to_Reg(memToReg[1]),
      .RegWrite(regWrite[1]), .MemWrite(memWrite[1]), .state(state[1]),
      .illegal(illegal[1]), .retired(retired[1]));

   multicycle_controller #(.MEM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .OpCode(OpCode), .func(func), .Zero(Zero), .Gtz(Gtz),
      .PCWrite(pcWrite[2]), .PCSrc(pcSrc[2]), .IRWrite(irWrite[2]), .RegDst(regDst[2]),
      .ALUSrc(aluSrc[2]), .Extop(extop[2]), .ALUop(aluOp[2]), .Mem_to_Reg(memToReg[2]),
      .RegWrite(regWrite[2]), .MemWrite(memWrite[2]), .state(state[2]),
      .illegal(illegal[2]), .retired(retired[2]));

   task automatic nextCycle();
      @(negedge clk);
      #1;
   endtask

   // Leaves every instance in the first IF cycle with the given instruction on the IR lines.
   task automatic applyReset(input logic [5:0] op, input logic [5:0] fn);
      @(negedge clk);
      reset  = 1'b1;
      OpCode = op;
      func   = fn;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset  = 1'b1;
      OpCode = 6'b100011;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (state[d] !== 3'd0) $display("FAIL reset_state dut%0d: got %0d expected 0", d, state[d]);
         else passed++;
         checks++;
         if (retired[d] !== 32'd0) $display("FAIL reset_retired dut%0d: got %0d expected 0", d, retired[d]);
         else passed++;
         checks++;
         if ({pcWrite[d], irWrite[d], regWrite[d], memWrite[d], illegal[d]} !== 5'b0)
            $display("FAIL reset_enables dut%0d: got %b expected 00000", d,
                     {pcWrite[d], irWrite[d], regWrite[d], memWrite[d], illegal[d]});
         else passed++;
         checks++;
         if ({pcSrc[d], regDst[d], aluSrc[d], extop[d], aluOp[d], memToReg[d]} !== 12'b0)
            $display("FAIL reset_selects dut%0d: got %b expected 0", d,
                     {pcSrc[d], regDst[d], aluSrc[d], extop[d], aluOp[d], memToReg[d]});
         else passed++;
      end
   endtask

   task automatic test_addu();
      int expSt[5] = '{0, 1, 2, 4, 0};
      int wbCount = 0;
      applyReset(6'b000000, 6'b100001);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (state[0] !== 3'(expSt[i])) $display("FAIL addu_state c%0d: got %0d expected %0d", i, state[0], expSt[i]);
         else passed++;
         if (i < 4 && regWrite[0] === 1'b1) wbCount++;
         if (i == 3) begin
            checks++;
            if (regDst[0] !== 2'b01 || aluOp[0] !== 3'd0)
               $display("FAIL addu_selects: got RegDst=%b ALUop=%0d expected 01/0", regDst[0], aluOp[0]);
            else passed++;
            checks++;
            if (regWrite[0] !== 1'b1) $display("FAIL addu_wb_regwrite: got %b expected 1", regWrite[0]);
            else passed++;
         end
         if (i < 4) nextCycle();
      end
      checks++;
      if (wbCount !== 1) $display("FAIL addu_regwrite_count: got %0d expected 1", wbCount);
      else passed++;
      checks++;
      if (retired[0] !== 32'd1) $display("FAIL addu_retired: got %0d expected 1", retired[0]);
      else passed++;
   endtask

   task automatic test_lw_lat3();
      int expSt[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
      int irCount = 0;
      int rwCount = 0;
      applyReset(6'b100011, 6'b000000);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (state[2] !== 3'(expSt[i])) $display("FAIL lw_state c%0d: got %0d expected %0d", i, state[2], expSt[i]);
         else passed++;
         if (i < 9 && irWrite[2] === 1'b1) irCount++;
         if (i < 9 && regWrite[2] === 1'b1) rwCount++;
         if (i == 8) begin
            checks++;
            if (memToReg[2] !== 2'b01 || extop[2] !== 2'b01 || aluSrc[2] !== 1'b1)
               $display("FAIL lw_selects: got M2R=%b Extop=%b ALUSrc=%b expected 01/01/1",
                        memToReg[2], extop[2], aluSrc[2]);
            else passed++;
         end
         if (i < 9) nextCycle();
      end
      checks++;
      if (irCount !== 1) $display("FAIL lw_irwrite_count: got %0d expected 1", irCount);
      else passed++;
      checks++;
      if (rwCount !== 1) $display("FAIL lw_regwrite_count: got %0d expected 1", rwCount);
      else passed++;
      checks++;
      if (retired[2] !== 32'd1) $display("FAIL lw_retired: got %0d expected 1", retired[2]);
      else passed++;
   endtask

   task automatic test_sw_lat2();
      int expSt[7] = '{0, 0, 1, 2, 3, 3, 0};
      int rwCount = 0;
      applyReset(6'b101011, 6'b000000);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (state[1] !== 3'(expSt[i])) $display("FAIL sw_state c%0d: got %0d expected %0d", i, state[1], expSt[i]);
         else passed++;
         if (i < 6) begin
            checks++;
            if (memWrite[1] !== (i == 5)) $display("FAIL sw_memwrite c%0d: got %b expected %b", i, memWrite[1], (i == 5));
            else passed++;
            if (regWrite[1] === 1'b1) rwCount++;
            nextCycle();
         end
      end
      checks++;
      if (rwCount !== 0) $display("FAIL sw_regwrite_count: got %0d expected 0", rwCount);
      else passed++;
   endtask

   task automatic test_branch(input logic [5:0] op, input logic z, input logic g, input logic expPw);
      applyReset(op, 6'b000000);
      Zero = z;
      Gtz  = g;
      nextCycle();
      nextCycle();
      checks++;
      if (state[0] !== 3'd2 || pcWrite[0] !== expPw || pcSrc[0] !== 2'b01 || aluOp[0] !== 3'd1)
         $display("FAIL branch_exe op=%b z=%b g=%b: got st=%0d PCWrite=%b PCSrc=%b ALUop=%0d expected 2/%b/01/1",
                  op, z, g, state[0], pcWrite[0], pcSrc[0], aluOp[0], expPw);
      else passed++;
      nextCycle();
      checks++;
      if (state[0] !== 3'd0 || retired[0] !== 32'd1)
         $display("FAIL branch_done op=%b: got st=%0d retired=%0d expected 0/1", op, state[0], retired[0]);
      else passed++;
      Zero = 1'b0;
      Gtz  = 1'b0;
   endtask

   task automatic test_jumps();
      applyReset(6'b000011, 6'b000000);
      nextCycle();
      checks++;
      if (state[0] !== 3'd1 || pcWrite[0] !== 1'b1 || pcSrc[0] !== 2'b10 || regWrite[0] !== 1'b1 ||
          regDst[0] !== 2'b10 || memToReg[0] !== 2'b10)
         $display("FAIL jal_id: got st=%0d PCW=%b PCSrc=%b RW=%b RegDst=%b M2R=%b expected 1/1/10/1/10/10",
                  state[0], pcWrite[0], pcSrc[0], regWrite[0], regDst[0], memToReg[0]);
      else passed++;
      nextCycle();
      checks++;
      if (state[0] !== 3'd0 || retired[0] !== 32'd1)
         $display("FAIL jal_done: got st=%0d retired=%0d expected 0/1", state[0], retired[0]);
      else passed++;

      applyReset(6'b000000, 6'b001000);
      nextCycle();
      checks++;
      if (pcWrite[0] !== 1'b1 || pcSrc[0] !== 2'b11 || regWrite[0] !== 1'b0)
         $display("FAIL jr_id: got PCW=%b PCSrc=%b RW=%b expected 1/11/0", pcWrite[0], pcSrc[0], regWrite[0]);
      else passed++;
      nextCycle();
      checks++;
      if (state[0] !== 3'd0) $display("FAIL jr_done: got st=%0d expected 0", state[0]);
      else passed++;
   endtask

   task automatic test_illegal();
      applyReset(6'b111111, 6'b000000);
      checks++;
      if (illegal[0] !== 1'b0) $display("FAIL illegal_if: got %b expected 0", illegal[0]);
      else passed++;
      nextCycle();
      checks++;
      if (state[0] !== 3'd1 || illegal[0] !== 1'b1 || {pcWrite[0], regWrite[0], memWrite[0]} !== 3'b0)
         $display("FAIL illegal_id: got st=%0d illegal=%b writes=%b expected 1/1/000",
                  state[0], illegal[0], {pcWrite[0], regWrite[0], memWrite[0]});
      else passed++;
      nextCycle();
      checks++;
      if (state[0] !== 3'd0 || illegal[0] !== 1'b0 || retired[0] !== 32'd0)
         $display("FAIL illegal_after: got st=%0d illegal=%b retired=%0d expected 0/0/0",
                  state[0], illegal[0], retired[0]);
      else passed++;
   endtask

   task automatic test_reset_mid_sw();
      applyReset(6'b101011, 6'b000000);
      for (int i = 0; i < 6; i++) nextCycle();
      checks++;
      if (retired[1] !== 32'd1) $display("FAIL midrst_first_retire: got %0d expected 1", retired[1]);
      else passed++;
      for (int i = 0; i < 5; i++) nextCycle();
      checks++;
      if (state[1] !== 3'd3 || memWrite[1] !== 1'b1)
         $display("FAIL midrst_before: got st=%0d MemWrite=%b expected 3/1", state[1], memWrite[1]);
      else passed++;
      reset = 1'b1;
      #1;
      checks++;
      if (memWrite[1] !== 1'b0 || state[1] !== 3'd0 || retired[1] !== 32'd0)
         $display("FAIL midrst_after: got MemWrite=%b st=%0d retired=%0d expected 0/0/0",
                  memWrite[1], state[1], retired[1]);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[4]   = '{6'b000000, 6'b001101, 6'b000000, 6'b000000};
      logic [5:0] fns[4]   = '{6'b100001, 6'b000000, 6'b100011, 6'b101010};
      logic [2:0] expAlu[4] = '{3'd0, 3'd2, 3'd1, 3'd3};
      applyReset(ops[0], fns[0]);
      for (int k = 0; k < 4; k++) begin
         OpCode = ops[k];
         func   = fns[k];
         #1;
         checks++;
         if (state[0] !== 3'd0 || aluOp[0] !== 3'd0)
            $display("FAIL b2b_if k%0d: got st=%0d ALUop=%0d expected 0/0", k, state[0], aluOp[0]);
         else passed++;
         nextCycle();
         nextCycle();
         nextCycle();
         checks++;
         if (state[0] !== 3'd4 || aluOp[0] !== expAlu[k])
            $display("FAIL b2b_wb k%0d: got st=%0d ALUop=%0d expected 4/%0d", k, state[0], aluOp[0], expAlu[k]);
         else passed++;
         nextCycle();
      end
      checks++;
      if (retired[0] !== 32'd4) $display("FAIL b2b_retired: got %0d expected 4", retired[0]);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_addu();
      test_lw_lat3();
      test_sw_lat2();
      test_branch(6'b000100, 1'b1, 1'b0, 1'b1);
      test_branch(6'b000100, 1'b0, 1'b1, 1'b0);
      test_branch(6'b000111, 1'b0, 1'b1, 1'b1);
      test_branch(6'b000111, 1'b1, 1'b0, 1'b0);
      test_jumps();
      test_illegal();
      test_reset_mid_sw();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle control decoder. It runs a 5-state FSM (IF/ID/EXE/MEM/WB) for the 14-instruction MIPS subset.
- Memory accesses use a configurable fixed wait latency. The block counts retired instructions.
- It sits between the instruction register (IR) and the multi-cycle datapath. It drives PC/IR/register-file/data-memory enables and mux selects per state.

Parameters:
- MEM_LAT, 1, cycles each IM/DM access occupies (legal 1..2^CNT_W-1).
- CNT_W, 4, width of the memory wait counter.
- ALUOP_W, 3, ALUop width; codes: 0 add, 1 sub, 2 or, 3 slt; other codes reserved.
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- OpCode  in  6  IR[31:26]; valid from ID onward (IR held by IRWrite).
- func  in  6  IR[5:0].
- Zero  in  1  ALU result == 0 (beq).
- Gtz  in  1  rs signed > 0 (bgtz).
- PCWrite  out  1  PC load enable.
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 rs (jr).
- IRWrite  out  1  IR load enable.
- RegDst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- ALUSrc  out  1  ALU B operand: 0 rt, 1 extended immediate.
- Extop  out  2  immediate extension: 00 zero, 01 sign, 10 lui.
- ALUop  out  ALUOP_W  ALU operation code (see ALUOP_W).
- Mem_to_Reg  out  2  register write-back source: 00 ALU, 01 DM, 10 PC+4.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  data-memory write enable.
- state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4.
- illegal  out  1  one-cycle pulse in ID on an undecoded instruction.
- retired  out  RET_W  count of completed instructions.

Behaviour:
- Reset (async, while high):
  - state=IF, wait counter=0, retired=0.
  - All enables (PCWrite, IRWrite, RegWrite, MemWrite, illegal) are 0.
  - All selects are 0.
- Decoded opcodes: addu/subu/slt/jr (op 000000; func 100001/100011/101010/001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, addi 001000, addiu 001001, jal 000011, bgtz 000111.
- Selects (RegDst, ALUSrc, Extop, ALUop, Mem_to_Reg):
  - Driven combinationally from OpCode/func in ID, EXE, MEM, WB; 0 in IF.
  - Values per instruction: R-type RegDst=01, slt ALUop=3, subu ALUop=1; ori Extop=00, ALUop=2; lui Extop=10; lw/sw/addi/addiu Extop=01, ALUop=0, ALUSrc=1; beq/bgtz ALUop=1; jal RegDst=10, Mem_to_Reg=10; lw Mem_to_Reg=01.
- Wait counter: cleared on entry to IF and MEM; increments each cycle in those states. The access completes when counter==MEM_LAT-1.
- IF:
  - On the completing cycle: IRWrite=1, PCWrite=1, PCSrc=00, then go to ID.
  - Otherwise stay in IF with all enables 0.
- ID:
  - j: PCWrite=1, PCSrc=10; go to IF.
  - jal: as j, plus RegWrite=1 (writes PC+4 to $31); go to IF.
  - jr: PCWrite=1, PCSrc=11; go to IF.
  - Undecoded op/func: illegal=1, no writes; go to IF. Does not increment retired.
  - All other decoded instructions: go to EXE.
- EXE:
  - beq: PCWrite=Zero, PCSrc=01; go to IF.
  - bgtz: PCWrite=Gtz, PCSrc=01; go to IF.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM:
  - sw: MemWrite=1 on the completing cycle only; then go to IF.
  - lw: on the completing cycle go to WB.
- WB: RegWrite=1 for exactly one cycle; go to IF.
- retired: increments by 1 on every transition into IF except from the illegal path. Wraps modulo 2^RET_W.
- No instruction asserts RegWrite and MemWrite together. Each write enable is high for at most one cycle per instruction.
- Reset asserted mid-instruction: immediate return to IF with all enables dropped in the same cycle (no partial write).
- OpCode/func changes outside ID..WB are ignored.

Test Plan:
- MEM_LAT=1, addu → states 0,1,2,4,0 (4 cycles); RegDst=01, ALUop=0; RegWrite high only in WB; retired 0→1.
- MEM_LAT=3, lw → IF 3 cycles, ID, EXE, MEM 3 cycles, WB = 9 cycles; Mem_to_Reg=01, Extop=01; IRWrite once; RegWrite once.
- MEM_LAT=2, sw → MemWrite high exactly one cycle, on the 2nd MEM cycle; RegWrite never high; next state IF.
- beq with Zero=1 → PCWrite=1, PCSrc=01 in EXE; repeat with Zero=0 → PCWrite=0. Same pair for bgtz with Gtz.
- jal → ID asserts PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, Mem_to_Reg=10; 2 cycles total at MEM_LAT=1. jr → PCSrc=11.
- OpCode=111111 → illegal pulses 1 cycle in ID, retired unchanged. Reset raised during MEM of sw → MemWrite=0 immediately, state=0, retired=0.
